nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//  Multi-cycle WIDTH-bit adder built around one 4-bit ripple-carry slice (RCA_4bits).
//  Operands are captured on start, then processed one nibble per clock, LSB nibble first.
//  The slice carry is registered between nibbles.
//  Sits directly upstream of RCA_4bits as its operand sequencer/controller.
//  Gives a wide add at the area cost of a single 4-bit slice.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits; must be a multiple of 4 and >= 4
//  NIB    WIDTH/4 (derived localparam)  number of nibble steps per add
// PORTS
//  clk    in   1      single clock, all state updates on rising edge
//  rst    in   1      asynchronous, active-high reset
//  start  in   1      request: capture a, b, cin and begin an add (honoured only in IDLE)
//  a      in   WIDTH  operand A (sampled only on accepted start)
//  b      in   WIDTH  operand B (sampled only on accepted start)
//  cin    in   1      carry-in (sampled only on accepted start)
//  busy   out  1      1 while state==RUN
//  done   out  1      one-cycle pulse: sum/cout just updated with new result
//  sum    out  WIDTH  registered result; holds last result until next completion
//  cout   out  1      registered carry-out of MSB nibble; holds like sum
// BEHAVIOUR
//  Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
//  Reset (async, any time incl. mid-RUN):
//   - state=IDLE, busy=0, done=0, sum=0, cout=0.
//   - Internal shift regs, carry reg and step counter cleared; the in-flight add is discarded.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 loads a_sh=a, b_sh=b, c_reg=cin, cnt=0, sum_sh=0; go RUN.
//   - RUN, each edge:
//     - Slice computes a_sh[3:0]+b_sh[3:0]+c_reg.
//     - sum_sh <= {slice_sum, sum_sh[WIDTH-1:4]}.
//     - a_sh and b_sh shift right by 4; c_reg <= slice_cout; cnt++.
//   - RUN, final step (cnt==NIB-1, edge E_NIB):
//     - sum <= {slice_sum, sum_sh[WIDTH-1:4]}, cout <= slice_cout.
//     - done <= 1; go DONE.
//   - DONE: lasts exactly one cycle; done=1, busy=0; next edge -> IDLE, done <= 0.
//  Latency: done high in the cycle after edge E0+NIB, i.e. NIB cycles after start is sampled.
//   Issue interval is NIB+2 cycles.
//  start is ignored in RUN and DONE: no recapture, no restart, no error flag.
//  Holding start high continuously: a new add is accepted on each IDLE cycle.
//  a/b/cin may change freely after the accepting edge without affecting the add in flight.
//  sum/cout never show partial results. They change only at the final RUN edge or on reset.
//  Arithmetic is unsigned modulo 2^WIDTH. cout is the true carry out of bit WIDTH-1.
//  Counter width = max(1,$clog2(NIB)); cnt never wraps because RUN exits at NIB-1.
//  WIDTH=4: RUN lasts one cycle and behaves identically to a single RCA_4bits add plus registers.
// STRUCTURE
//  Shared package: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and SLICE_W=4.
//  One sub-module: the existing RCA_4bits, instantiated once as the datapath slice.
//   - Its inputs come from a_sh[3:0], b_sh[3:0] and c_reg.
//  Everything else (FSM, counter, shift regs, output regs) is local to this module.
//  No combinational path from start/a/b/cin to any output.
// TESTING (WIDTH=16 unless stated)
//  1. a=16'h0001 b=16'hFFFF cin=0 -> sum=16'h0000 cout=1.
//     done pulses exactly 4 cycles after start, 1 cycle wide.
//  2. a=16'hFFFF b=16'hFFFF cin=1 -> sum=16'hFFFF cout=1. busy=1 for exactly 4 cycles.
//  3. a=16'h1234 b=16'h4321 cin=0 -> sum=16'h5555 cout=0.
//     Pulse start with a=b=16'hFFFF at RUN cycle 2 -> ignored, result still 16'h5555.
//  4. Start a=16'h00FF b=16'h0001 cin=0, assert rst during RUN cycle 2:
//     - Immediately busy=0, done=0, sum=0, cout=0.
//     - After release, a=16'h0F0F b=16'h00F1 cin=0 -> sum=16'h1000 cout=0.
//  5. start held high, alternating operands:
//     - New add accepted every 6 cycles.
//     - Each done matches its operands: 16'h8000+16'h8000 -> sum=16'h0000 cout=1.
//  6. WIDTH=4 instance: a=4'h7 b=4'h7 cin=0 -> sum=4'hE cout=0, done 1 cycle after start.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and slice width.
// No ports; imported by the interface-facing top and the datapath slice.
package nibble_serial_adder_pkg;

  // Width of the single ripple-carry slice that all adds are folded through.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result bundle for the nibble-serial adder.
// master: drives start/a/b/cin, observes busy/done/sum/cout.
// slave : the adder; samples start/a/b/cin, drives busy/done/sum/cout.
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder_rca4.sv
// 4-bit ripple-carry adder slice (RCA_4bits), purely combinational.
// Ports: a, b (4-bit operands), cin (carry in) -> sum (4-bit), cout (carry out).
// The nibble-serial adder reuses this one slice for every nibble of a wide add.
module rca_4bits
  import nibble_serial_adder_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic carry;

  // Explicit full-adder chain so the slice stays a true ripple adder.
  always_comb begin
    carry = cin;
    sum   = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit unsigned adder: captures a/b/cin on start (IDLE only), then adds
// one nibble per clock LSB-first through a single rca_4bits slice, carry registered between nibbles.
// Ports: clk, rst (async, active-high), bus (slave: start/a/b/cin in; busy/done/sum/cout out).
// done pulses NIB cycles after start is sampled; start is ignored while RUN or DONE (interval NIB+2).
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NIB = WIDTH / SLICE_W;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_sh;
  logic               c_reg;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               busy_q;
  logic               done_q;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [WIDTH-1:0]   sum_next;

  rca_4bits u_slice (
    .a    (a_sh[SLICE_W-1:0]),
    .b    (b_sh[SLICE_W-1:0]),
    .cin  (c_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // New nibble enters at the top; after NIB steps the first nibble has reached bit 0.
  // Written as a shift of the concatenation so WIDTH==4 (no older nibbles) needs no special case.
  assign sum_next = WIDTH'({slice_sum, sum_sh} >> SLICE_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            c_reg  <= bus.cin;
            cnt    <= '0;
            sum_sh <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> SLICE_W;
          b_sh   <= b_sh >> SLICE_W;
          c_reg  <= slice_cout;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NIB - 1)) begin
            // Only the final step publishes; sum/cout never expose partial results.
            sum_q  <= sum_next;
            cout_q <= slice_cout;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16 and WIDTH=4 instances).
// A cycle-level reference of the IDLE/RUN/DONE protocol predicts busy/done each cycle;
// expected sums are queued when a start is accepted and popped when the DUT raises done.
module tb_nibble_serial_adder;

  localparam int W    = 16;
  localparam int NIB  = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fin = 1'b0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus  ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  nibble_serial_adder #(.WIDTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference + scoreboard (one process, checks at negedge) ----------------
  logic [16:0] q16[$];
  logic [4:0]  q4[$];

  initial begin
    int          m_st  = 0;  // 0 idle, 1 run, 2 done
    int          m_cnt = 0;
    int          m4_st = 0;
    int          cyc   = 0;
    logic [16:0] hold16 = '0;
    logic [4:0]  hold4  = '0;
    logic [16:0] e16;
    logic [4:0]  e4;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res",  32'({bus.cout, bus.sum}), 0);
        chk("rst_res4", 32'({bus4.cout, bus4.sum, bus4.busy, bus4.done}), 0);
        m_st = 0; m_cnt = 0; m4_st = 0;
        hold16 = '0; hold4 = '0;
        q16.delete(); q4.delete();
      end else begin
        // --- compare 16-bit instance against the reference ---
        chk("busy", 32'(bus.busy), 32'(m_st == 1));
        chk("done", 32'(bus.done), 32'(m_st == 2));
        if (bus.done) begin
          if (q16.size() == 0) chk("sb16_empty", 1, 0);
          else begin
            e16 = q16.pop_front();
            chk("result", 32'({bus.cout, bus.sum}), 32'(e16));
            hold16 = e16;
          end
        end else chk("hold", 32'({bus.cout, bus.sum}), 32'(hold16));

        // --- compare 4-bit instance ---
        chk("busy4", 32'(bus4.busy), 32'(m4_st == 1));
        chk("done4", 32'(bus4.done), 32'(m4_st == 2));
        if (bus4.done) begin
          if (q4.size() == 0) chk("sb4_empty", 1, 0);
          else begin
            e4 = q4.pop_front();
            chk("result4", 32'({bus4.cout, bus4.sum}), 32'(e4));
            hold4 = e4;
          end
        end else chk("hold4", 32'({bus4.cout, bus4.sum}), 32'(hold4));

        // --- advance reference by the upcoming rising edge (inputs are stable now) ---
        case (m_st)
          0: if (bus.start) begin
               q16.push_back({1'b0, bus.a} + {1'b0, bus.b} + 17'(bus.cin));
               m_st = 1; m_cnt = 0;
             end
          1: if (m_cnt == NIB - 1) m_st = 2; else m_cnt++;
          default: m_st = 0;
        endcase
        case (m4_st)
          0: if (bus4.start) begin
               q4.push_back({1'b0, bus4.a} + {1'b0, bus4.b} + 5'(bus4.cin));
               m4_st = 1;
             end
          1: m4_st = 2;
          default: m4_st = 0;
        endcase
      end

      if (cyc > 3000) begin
        chk("timeout", 1, 0);
        fin = 1'b1;
      end
      if (fin) begin
        chk("sb16_drained", 32'(q16.size()), 0);
        chk("sb4_drained",  32'(q4.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  // ---------------- stimulus (changes 2ns after rising edges) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One start pulse; operands scrambled right after acceptance to prove they were captured.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin;
    tick(1);
    bus.start = 1'b0; bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic cin);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
    tick(1);
    bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom);
  endtask

  initial begin
    bus.start  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0;
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // 1. carry ripples through every nibble
    issue(16'h0001, 16'hFFFF, 1'b0); tick(7);
    // 2. all ones plus carry-in
    issue(16'hFFFF, 16'hFFFF, 1'b1); tick(7);
    // 3. start pulsed mid-RUN must be ignored
    issue(16'h1234, 16'h4321, 1'b0);
    tick(1);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(6);
    // 4. async reset in RUN cycle 2 discards the add, then a clean add follows
    issue(16'h00FF, 16'h0001, 1'b0);
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    issue(16'h0F0F, 16'h00F1, 1'b0); tick(7);
    // 5. start held high: accepted every NIB+2 cycles, operands alternating
    bus.start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) begin bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b0; end
      else begin bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom); end
      tick(1);
    end
    bus.start = 1'b0;
    tick(8);
    // 6. WIDTH=4 instance, plus a few random adds on both
    issue4(4'h7, 4'h7, 1'b0); tick(3);
    issue4(4'hF, 4'hF, 1'b1); tick(3);
    for (int i = 0; i < 6; i++) begin
      issue(16'($urandom), 16'($urandom), 1'($urandom));
      issue4(4'($urandom), 4'($urandom), 1'($urandom));
      tick(6);
    end
    tick(4);
    fin = 1'b1;
  end

endmodule
